yarp_mem_arbiter: RTL

Shares the core's single memory port between instruction fetch and load/store. Sits between the fetch unit, the load/store unit and the external memory interface. Runs one transaction at a time with a valid/grant/response handshake on every side. Data requests have priority, bounded by an anti-starvation counter that protects fetch.

---
 rtl/yarp_pkg.sv | 11 +
 rtl/yarp_mem_arb_prio.sv | 47 ++++
 rtl/yarp_mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/yarp_pkg.sv
// Shared types for the yarp memory-port arbiter: FSM states, owner tag, access sizes.
package yarp_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b11;

endpackage

// File: rtl/yarp_mem_arb_prio.sv
// Fetch/data priority pick: data wins contention until fetch has lost STARVE_MAX
// contested rounds in a row. Grants are combinational; the streak updates on the grant edge.
module yarp_mem_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_en_i,
  input  logic imem_req_i,
  input  logic dmem_req_i,
  output logic grant_i,
  output logic grant_d
);

  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                starved;

  assign starved = (streak_q == STREAK_MAX);

  always_comb begin
    grant_d  = arb_en_i && dmem_req_i && !(imem_req_i && starved);
    grant_i  = arb_en_i && imem_req_i && !grant_d;
    streak_d = streak_q;
    // Only data grants that actually beat a waiting fetch extend the streak.
    if (grant_d) begin
      if (!imem_req_i) begin
        streak_d = '0;
      end else if (!starved) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end else if (grant_i) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/yarp_mem_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction at a time.
// Min req-to-rvalid latency 3 cycles; requests arriving outside IDLE wait there for a grant.
module yarp_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              imem_req_i,
  input  logic [ADDR_W-1:0] imem_addr_i,
  output logic              imem_gnt_o,
  output logic              imem_rvalid_o,
  output logic [DATA_W-1:0] imem_rdata_o,
  input  logic              dmem_req_i,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic              dmem_wr_i,
  input  logic [1:0]        dmem_byte_i,
  input  logic [DATA_W-1:0] dmem_wdata_i,
  output logic              dmem_gnt_o,
  output logic              dmem_rvalid_o,
  output logic [DATA_W-1:0] dmem_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [1:0]        mem_byte_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [1:0]        byte_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              grant_i, grant_d;

  yarp_mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk        (clk),
    .reset_n    (reset_n),
    .arb_en_i   (state_q == IDLE),
    .imem_req_i (imem_req_i),
    .dmem_req_i (dmem_req_i),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  always_comb begin
    state_d       = state_q;
    mem_req_o     = 1'b0;
    imem_rvalid_o = 1'b0;
    dmem_rvalid_o = 1'b0;
    case (state_q)
      IDLE: if (grant_i || grant_d) state_d = REQ;
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: if (mem_rvalid_i) state_d = RESP;
      RESP: begin
        imem_rvalid_o = (owner_q == OWN_I);
        dmem_rvalid_o = (owner_q == OWN_D);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch is a plain word read, so its write-side fields are forced to neutral values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        owner_q <= OWN_D;
        addr_q  <= dmem_addr_i;
        wr_q    <= dmem_wr_i;
        byte_q  <= dmem_byte_i;
        wdata_q <= dmem_wdata_i;
      end else if (grant_i) begin
        owner_q <= OWN_I;
        addr_q  <= imem_addr_i;
        wr_q    <= 1'b0;
        byte_q  <= WORD;
        wdata_q <= '0;
      end
      if (state_q == WAIT && mem_rvalid_i) rdata_q <= mem_rdata_i;
    end
  end

  assign imem_gnt_o   = grant_i;
  assign dmem_gnt_o   = grant_d;
  assign imem_rdata_o = rdata_q;
  assign dmem_rdata_o = rdata_q;
  assign mem_addr_o   = addr_q;
  assign mem_wr_o     = wr_q;
  assign mem_byte_o   = byte_q;
  assign mem_wdata_o  = wdata_q;

endmodule
